// File: rtl/pl_pkg.sv
// Shared definitions for the pipeline data-memory path: controller state
// encoding, load/store funct3 codes and access-size codes.
package pl_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'b00,
        DMEM_BUSY = 2'b01,
        DMEM_DONE = 2'b10
    } dmem_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Access size is carried in funct3[1:0] for both loads and stores.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

endpackage

// File: rtl/pl_dmem_align.sv
// Byte-lane logic for the data-memory controller: store byte enables and
// lane replication, misalignment detection, load extraction and extension.
// Purely combinational.
module pl_dmem_align
    import pl_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Store lanes and alignment check from the access size and address offset.
    always_comb begin
        be         = 4'b0000;
        wdata      = 32'h0000_0000;
        misaligned = 1'b0;
        case (st_size)
            SZ_BYTE: begin
                be    = 4'b0001 << st_addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                be         = 4'b0011 << st_addr_lo;
                wdata      = {2{st_data[15:0]}};
                misaligned = st_addr_lo[0];
            end
            default: begin
                be         = 4'b1111;
                wdata      = st_data;
                misaligned = (st_addr_lo != 2'b00);
            end
        endcase
    end

    // Select the addressed byte/half of the read word and extend it.
    always_comb begin
        ld_byte_s = 8'h00;
        ld_half_s = 16'h0000;
        ld_data   = 32'h0000_0000;
        case (ld_addr_lo)
            2'b00:   ld_byte_s = ld_word[7:0];
            2'b01:   ld_byte_s = ld_word[15:8];
            2'b10:   ld_byte_s = ld_word[23:16];
            default: ld_byte_s = ld_word[31:24];
        endcase
        if (ld_addr_lo[1]) begin
            ld_half_s = ld_word[31:16];
        end else begin
            ld_half_s = ld_word[15:0];
        end
        case (ld_funct3)
            F3_LB:   ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
            F3_LH:   ld_data = {{16{ld_half_s[15]}}, ld_half_s};
            F3_LBU:  ld_data = {24'h00_0000, ld_byte_s};
            F3_LHU:  ld_data = {16'h0000, ld_half_s};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/pl_dmem_ctrl.sv
// M-stage data-memory access controller. Sequences one load/store at a time
// over a req/ack bus, stalls the pipeline while the access is outstanding,
// and abandons the access with a fault after TIMEOUT_CYCLES busy cycles.
module pl_dmem_ctrl
    import pl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        MemStall,
    output logic        MemBubbleW,
    output logic        MemFaultM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dmem_state_t      state_r;
    dmem_state_t      state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             req_r;
    logic             we_r;
    logic [31:0]      addr_r;
    logic [3:0]       be_r;
    logic [31:0]      wdata_r;
    logic [2:0]       funct3_r;
    logic [1:0]       addr_lo_r;
    logic [31:0]      rdata_r;
    logic             fault_r;

    logic             start_s;
    logic             misalign_go_s;
    logic             ack_s;
    logic             timeout_s;
    logic [3:0]       be_s;
    logic [31:0]      wdata_s;
    logic             misaligned_s;
    logic [31:0]      ld_data_s;

    pl_dmem_align u_align (
        .st_size    (funct3M[1:0]),
        .st_addr_lo (ALUResultM[1:0]),
        .st_data    (WriteDataM),
        .ld_funct3  (funct3_r),
        .ld_addr_lo (addr_lo_r),
        .ld_word    (rdata_r),
        .be         (be_s),
        .wdata      (wdata_s),
        .misaligned (misaligned_s),
        .ld_data    (ld_data_s)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= DMEM_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode, datapath strobes and pipeline-facing outputs.
    always_comb begin
        state_nxt_s   = state_r;
        start_s       = 1'b0;
        misalign_go_s = 1'b0;
        ack_s         = 1'b0;
        timeout_s     = 1'b0;
        MemStall      = 1'b0;
        MemFaultM     = 1'b0;
        ReadDataM     = 32'h0000_0000;
        case (state_r)
            DMEM_IDLE: begin
                MemStall = MemReqM;
                if (MemReqM) begin
                    if (misaligned_s) begin
                        misalign_go_s = 1'b1;
                        state_nxt_s   = DMEM_DONE;
                    end else begin
                        start_s     = 1'b1;
                        state_nxt_s = DMEM_BUSY;
                    end
                end else begin
                    state_nxt_s = DMEM_IDLE;
                end
            end
            DMEM_BUSY: begin
                MemStall = 1'b1;
                // An ack on the final allowed cycle still completes normally.
                if (dmem_ack) begin
                    ack_s       = 1'b1;
                    state_nxt_s = DMEM_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = DMEM_DONE;
                end else begin
                    state_nxt_s = DMEM_BUSY;
                end
            end
            DMEM_DONE: begin
                // The completing instruction still drives MemReqM here, so
                // no new access may start from this state.
                MemFaultM = fault_r;
                if (!fault_r && !we_r) begin
                    ReadDataM = ld_data_s;
                end else begin
                    ReadDataM = 32'h0000_0000;
                end
                state_nxt_s = DMEM_IDLE;
            end
            default: begin
                state_nxt_s = DMEM_IDLE;
            end
        endcase
        MemBubbleW = MemStall;
    end

    // Latched access fields, bus request, timeout counter and read capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CNT_W{1'b0}};
            req_r     <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= 32'h0000_0000;
            be_r      <= 4'b0000;
            wdata_r   <= 32'h0000_0000;
            funct3_r  <= 3'b000;
            addr_lo_r <= 2'b00;
            rdata_r   <= 32'h0000_0000;
            fault_r   <= 1'b0;
        end else if (start_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            req_r     <= 1'b1;
            we_r      <= MemWriteM;
            addr_r    <= {ALUResultM[31:2], 2'b00};
            be_r      <= be_s;
            wdata_r   <= wdata_s;
            funct3_r  <= funct3M;
            addr_lo_r <= ALUResultM[1:0];
            rdata_r   <= 32'h0000_0000;
            fault_r   <= 1'b0;
        end else if (misalign_go_s) begin
            rdata_r <= 32'h0000_0000;
            fault_r <= 1'b1;
        end else if (ack_s) begin
            req_r   <= 1'b0;
            rdata_r <= dmem_rdata;
        end else if (timeout_s) begin
            req_r   <= 1'b0;
            rdata_r <= 32'h0000_0000;
            fault_r <= 1'b1;
        end else if (state_r == DMEM_BUSY) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else if (state_r == DMEM_DONE) begin
            fault_r <= 1'b0;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign dmem_req   = req_r;
    assign dmem_we    = we_r;
    assign dmem_addr  = addr_r;
    assign dmem_be    = be_r;
    assign dmem_wdata = wdata_r;

endmodule

// File: tb/tb_pl_dmem_ctrl.sv
// Self-checking bench for pl_dmem_ctrl. Each access is described as a
// cycle timeline (request cycle, bus cycles, completion cycle) and the
// expected outputs for every cycle come from size/offset arithmetic.
`timescale 1ns/1ps
module tb_pl_dmem_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemReqM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        MemStall, MemBubbleW, MemFaultM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int n_vec = 0;
    int n_err = 0;

    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_fault, exp_done, exp_we;
    logic [31:0] exp_read, exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    int          cnt_req, cnt_stall, cnt_fault;
    logic [31:0] obs_read, obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_we;

    pl_dmem_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemReqM    (MemReqM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .MemStall   (MemStall),
        .MemBubbleW (MemBubbleW),
        .MemFaultM  (MemFaultM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = m_size(f3);
        if (sz == 4) return 4'hF;
        return 4'(((1 << sz) - 1) << int'(a[1:0]));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        int sz = m_size(f3);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        int sz = m_size(f3);
        v = rd >> (8 * int'(a[1:0]));
        if (sz == 1) begin
            v = v & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v - 32'h100;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v - 32'h1_0000;
        end
        return v;
    endfunction

    // ---------------- per-cycle comparison ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("MemStall",   32'(MemStall),   32'(exp_stall));
                check("MemBubbleW", 32'(MemBubbleW), 32'(exp_stall));
                check("MemFaultM",  32'(MemFaultM),  32'(exp_fault));
                check("dmem_req",   32'(dmem_req),   32'(exp_req));
                check("ReadDataM",  ReadDataM,       exp_read);
                if (exp_req) begin
                    check("dmem_we",    32'(dmem_we), 32'(exp_we));
                    check("dmem_addr",  dmem_addr,    exp_addr);
                    check("dmem_be",    32'(dmem_be), 32'(exp_be));
                    check("dmem_wdata", dmem_wdata,   exp_wdata);
                end
                if (MemStall)  cnt_stall++;
                if (MemFaultM) cnt_fault++;
                if (dmem_req) begin
                    cnt_req++;
                    obs_we    = dmem_we;
                    obs_addr  = dmem_addr;
                    obs_be    = dmem_be;
                    obs_wdata = dmem_wdata;
                end
                if (exp_done) obs_read = ReadDataM;
            end
        end
    end

    // One access from the M-stage request through its completion cycle.
    // ack_at: bus cycle (1-based) carrying dmem_ack; 0 or > T means none.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
        logic mis, fault;
        int   nbus, done_k;
        mis    = m_mis(f3, a);
        nbus   = mis ? 0 : ((ack_at >= 1 && ack_at <= T) ? ack_at : T);
        done_k = nbus + 1;
        fault  = mis || (ack_at < 1 || ack_at > T);
        cnt_req = 0; cnt_stall = 0; cnt_fault = 0;
        obs_read = 32'hFFFF_FFFF; obs_be = 4'h0; obs_we = 1'b0;
        obs_addr = 32'h0; obs_wdata = 32'h0;
        for (int k = 0; k <= done_k; k++) begin
            MemReqM    = 1'b1;
            MemWriteM  = we;
            funct3M    = f3;
            ALUResultM = a;
            WriteDataM = wd;
            dmem_ack   = (k >= 1 && k <= nbus && k == ack_at) || (k == done_k);
            dmem_rdata = (k == ack_at) ? rd : 32'h5A5A_5A5A;
            exp_stall  = (k < done_k);
            exp_req    = (k >= 1 && k <= nbus);
            exp_done   = (k == done_k);
            exp_fault  = exp_done && fault;
            exp_read   = (exp_done && !fault && !we) ? m_load(f3, a, rd) : 32'h0;
            exp_we     = we;
            exp_addr   = {a[31:2], 2'b00};
            exp_be     = m_be(f3, a);
            exp_wdata  = m_wdata(f3, wd);
            chk_en     = 1'b1;
            @(posedge clk); #1;
        end
        MemReqM  = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic idle(input int n, input logic ack);
        for (int i = 0; i < n; i++) begin
            MemReqM   = 1'b0;
            dmem_ack  = ack;
            exp_stall = 1'b0; exp_req = 1'b0; exp_fault = 1'b0;
            exp_done  = 1'b0; exp_read = 32'h0;
            chk_en    = 1'b1;
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; MemReqM = 1'b0; MemWriteM = 1'b0; funct3M = 3'b000;
        ALUResultM = 32'h0; WriteDataM = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_fault = 1'b0; exp_done = 1'b0;
        exp_we = 1'b0; exp_read = 32'h0; exp_addr = 32'h0; exp_wdata = 32'h0; exp_be = 4'h0;
        #3;
        check("rst dmem_req",   32'(dmem_req),  32'd0);
        check("rst dmem_we",    32'(dmem_we),   32'd0);
        check("rst dmem_addr",  dmem_addr,      32'h0);
        check("rst dmem_be",    32'(dmem_be),   32'd0);
        check("rst dmem_wdata", dmem_wdata,     32'h0);
        check("rst MemFaultM",  32'(MemFaultM), 32'd0);
        check("rst ReadDataM",  ReadDataM,      32'h0);
        check("rst MemStall",   32'(MemStall),  32'd0);
        MemReqM = 1'b1; #1;
        check("rst MemStall follows req", 32'(MemStall),   32'd1);
        check("rst MemBubbleW",           32'(MemBubbleW), 32'd1);
        MemReqM = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        idle(2, 1'b0);

        // lw, ack on the first bus cycle
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 1);
        check("lw stall cycles", 32'(cnt_stall), 32'd2);
        check("lw req cycles",   32'(cnt_req),   32'd1);
        check("lw data",         obs_read,       32'hDEAD_BEEF);

        // lb with three wait states; ack lands on the last allowed cycle
        run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h8000_0000, 4);
        check("lb data",         obs_read,       32'hFFFF_FF80);
        check("lb be",           32'(obs_be),    32'h8);
        check("lb stall cycles", 32'(cnt_stall), 32'd5);
        check("lb fault cycles", 32'(cnt_fault), 32'd0);
        // lbu back-to-back
        run_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h8000_0000, 4);
        check("lbu data", obs_read, 32'h0000_0080);

        // halfword loads
        run_op(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 2);
        check("lh hi data", obs_read, 32'hFFFF_8001);
        run_op(1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_7FFF, 1);
        check("lhu hi data", obs_read, 32'h0000_8001);
        run_op(1'b0, 3'b001, 32'h100, 32'h0, 32'h8001_7FFF, 3);
        idle(1, 1'b0);

        // stores
        run_op(1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h1111_2222, 1);
        check("sh we",    32'(obs_we),  32'd1);
        check("sh be",    32'(obs_be),  32'hC);
        check("sh wdata", obs_wdata,    32'hABCD_ABCD);
        check("sh addr",  obs_addr,     32'h0000_0200);
        check("sh read",  obs_read,     32'h0);
        run_op(1'b1, 3'b000, 32'h001, 32'h1234_56EF, 32'h0, 2);
        check("sb wdata", obs_wdata, 32'hEFEF_EFEF);
        run_op(1'b1, 3'b010, 32'h10C, 32'hCAFE_F00D, 32'h0, 1);

        // misaligned accesses
        run_op(1'b0, 3'b010, 32'h101, 32'h0, 32'hFFFF_FFFF, 1);
        check("mis lw req cycles",   32'(cnt_req),   32'd0);
        check("mis lw fault cycles", 32'(cnt_fault), 32'd1);
        check("mis lw stall cycles", 32'(cnt_stall), 32'd1);
        check("mis lw data",         obs_read,       32'h0);
        run_op(1'b1, 3'b001, 32'h203, 32'h0000_5555, 32'h0, 1);

        // timeout, then late acks while idle
        run_op(1'b0, 3'b010, 32'h400, 32'h0, 32'h7777_7777, 0);
        check("tmo req cycles",   32'(cnt_req),   32'd4);
        check("tmo fault cycles", 32'(cnt_fault), 32'd1);
        idle(3, 1'b1);
        check("tmo late ack ignored", 32'(cnt_req), 32'd4);

        // reset in the middle of a bus access
        chk_en = 1'b0;
        MemReqM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h300;
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        check("busy dmem_req", 32'(dmem_req), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        check("async drop dmem_req", 32'(dmem_req),   32'd0);
        check("rst stall w/ req",    32'(MemStall),   32'd1);
        check("rst bubble w/ req",   32'(MemBubbleW), 32'd1);
        MemReqM = 1'b0; dmem_ack = 1'b1; #1;
        check("rst stall no req", 32'(MemStall),  32'd0);
        check("rst fault",        32'(MemFaultM), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        idle(2, 1'b1);
        run_op(1'b0, 3'b010, 32'h304, 32'h0, 32'h1357_9BDF, 1);
        check("post-rst lw data", obs_read, 32'h1357_9BDF);
        idle(1, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pl_dmem_ctrl.md
# pl_dmem_ctrl

Memory-stage data-memory access controller for the 5-stage RISC-V pipeline. It sequences load/store instructions in the M stage against a variable-latency data memory using a req/ack handshake. It holds the pipeline while the access is outstanding and drives bubbles into the memory/writeback pipeline register. It also performs byte-lane steering, store byte enables, load sign/zero extension, misalignment detection and bus-timeout detection.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of BUSY cycles without `dmem_ack` before the access is abandoned.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `MemReqM` input, 1: M-stage instruction is a load or store.
- `MemWriteM` input, 1: 1 = store, 0 = load.
- `funct3M` input, 3: access size/sign. 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store uses bits [1:0].
- `ALUResultM` input, 32: effective byte address.
- `WriteDataM` input, 32: store data, right-aligned.
- `ReadDataM` output, 32: extended load result, valid in DONE; 0 otherwise.
- `MemStall` output, 1: hold F/D/E/M pipeline registers (drives their `en`, 1 = hold).
- `MemBubbleW` output, 1: clear the memory/writeback register (drives its `clr`).
- `MemFaultM` output, 1: misaligned access or timeout; one-cycle pulse.
- `dmem_req` output, 1: bus request.
- `dmem_we` output, 1: bus write.
- `dmem_addr` output, 32: word address (`ALUResultM` with [1:0] = 0).
- `dmem_be` output, 4: byte enables.
- `dmem_wdata` output, 32: lane-steered store data.
- `dmem_ack` input, 1: access complete; `dmem_rdata` valid the same cycle.
- `dmem_rdata` input, 32: read word.

## Operation
- State machine has three states: IDLE, BUSY, DONE. Reset state is IDLE.
- **IDLE**
  - If `MemReqM` is set and the access is aligned, latch addr/we/be/wdata/funct3 and go to BUSY.
  - If `MemReqM` is set and the access is misaligned, go to DONE with the fault flag set. No bus request is issued.
  - If `MemReqM` is 0, stay in IDLE.
- **BUSY**
  - `dmem_req` = 1, with the latched fields held stable.
  - If `dmem_ack` is set, capture `dmem_rdata` and go to DONE.
  - Otherwise, if the timeout counter equals `TIMEOUT_CYCLES - 1`, set the fault flag, capture 0 and go to DONE.
  - Otherwise, increment the counter.
- **DONE**
  - The access has completed; the instruction advances this cycle.
  - Always return to IDLE. DONE never issues a request, because `MemReqM` still belongs to the completing instruction.
- Misalignment rule: halfword with addr[0] = 1, or word with addr[1:0] ≠ 0.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`.
  - halfword: `4'b0011 << addr[1:0]`.
  - word: `4'b1111`.
- Store data is replicated across lanes: byte → {4{b}}, half → {2{h}}.
- Load extraction: select a byte/half by the latched addr[1:0]. Sign-extend for lb/lh; zero-extend for lbu/lhu.
- On a fault, `ReadDataM` = 0. Stores always present `ReadDataM` = 0.
- `MemStall` = (IDLE & `MemReqM`) | BUSY.
- `MemBubbleW` = `MemStall`.
- `MemFaultM` = DONE & fault flag.

## Timing
- Reset values: state IDLE, `dmem_req`/`dmem_we` 0, `dmem_addr`/`dmem_wdata` 0, `dmem_be` 0, counter 0, capture register 0, fault flag 0.
- Combinational outputs follow from reset state: `MemStall` = `MemReqM`, `MemBubbleW` = `MemStall`, `MemFaultM` 0.
- Reset mid-access drops `dmem_req` immediately (asynchronous); any late ack is ignored.
- `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be` and `dmem_wdata` are registered. `dmem_req` rises the cycle after the IDLE request and falls the cycle after ack.
- `dmem_ack` is sampled only in BUSY and ignored in IDLE or DONE.
- Ack in the same cycle as the timeout: the ack wins and no fault is raised.
- Latency: ack in the first BUSY cycle gives a stall of 2 cycles, so the instruction occupies M for 3 cycles. Each extra wait cycle adds 1.
- Misaligned access: stall 1 cycle (IDLE), then DONE with the fault.
- Timeout: exactly `TIMEOUT_CYCLES` BUSY cycles, then DONE.
- Back-to-back memory ops: the second is seen in IDLE the cycle after DONE.

## Structure
- Shared package `pl_pkg` holds:
  - state encoding (`DMEM_IDLE`, `DMEM_BUSY`, `DMEM_DONE`);
  - funct3 constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`).
- Sub-module `pl_dmem_align` (purely combinational) holds all byte-lane and extension logic:
  - store: be/wdata generation;
  - misalignment detection;
  - load: extraction and extension.
- The FSM, counter and latches stay in `pl_dmem_ctrl`.

## Test plan
- **lw, ack in first BUSY cycle.** Addr 0x100, rdata 0xDEADBEEF.
  - `MemStall` high for 2 cycles.
  - In DONE, `ReadDataM` = 0xDEADBEEF and `MemBubbleW` = 0.
  - `dmem_req` high for exactly 1 cycle.
- **lb, wait states.** Addr 0x103, rdata 0x80000000, ack after 3 wait cycles.
  - `ReadDataM` = 0xFFFFFF80.
  - `dmem_be` = 4'b1000.
  - Stall lasts 5 cycles.
  - lbu variant gives 0x00000080.
- **sh.** Addr 0x202, data 0x0000ABCD.
  - `dmem_we` = 1, `dmem_be` = 4'b1100, `dmem_wdata` = 0xABCDABCD, `dmem_addr` = 0x200.
- **Misaligned lw.** Addr 0x101.
  - No `dmem_req`.
  - `MemFaultM` pulses in the second cycle; `ReadDataM` = 0.
- **Timeout.** `TIMEOUT_CYCLES` = 4, no ack.
  - `dmem_req` high for 4 cycles.
  - `MemFaultM` pulses; FSM returns to IDLE.
  - A subsequent ack is ignored.
- **Reset mid-BUSY.**
  - `dmem_req` drops asynchronously.
  - `MemStall` follows `MemReqM`.
  - A fresh lw after reset completes normally.
